dcache_write_buffer: RTL and testbench
======================================

Name: dcache_write_buffer

Overview:
- Store write buffer directly downstream of the data cache (write-through path).
- Accepts word writes with byte strobes from the cache and queues them in a FIFO.
- Drains them one at a time to the memory interface using a req/ack handshake.
- Provides a combinational address lookup so the cache can detect loads that hit still-pending stores.

Parameters:
ADDRESS_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width; must be a multiple of 8
DEPTH, 4, number of entries; power of 2, at least 2

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  reset, synchronous, active-low
WR_VALID  in  1  cache presents a write
WR_READY  out  1  buffer accepts the write this cycle
WR_ADDR  in  ADDRESS_WIDTH  write byte address
WR_DATA  in  DATA_WIDTH  write data
WR_STRB  in  DATA_WIDTH/8  byte enables
LOOKUP_ADDR  in  ADDRESS_WIDTH  load address to check
LOOKUP_HIT  out  1  some valid entry matches the word address
LOOKUP_DATA  out  DATA_WIDTH  data of the youngest matching entry
LOOKUP_STRB  out  DATA_WIDTH/8  strobes of the youngest matching entry
MEM_REQ  out  1  write request to memory
MEM_ADDR  out  ADDRESS_WIDTH  request address
MEM_DATA  out  DATA_WIDTH  request data
MEM_STRB  out  DATA_WIDTH/8  request strobes
MEM_ACK  in  1  memory completes the current request
EMPTY  out  1  no entries, including none in flight
FULL  out  1  count equals DEPTH

Behaviour:
- Reset (RST_N low at a rising edge):
  - Head/tail pointers = 0, count = 0, FSM = IDLE.
  - MEM_REQ = 0; MEM_ADDR/MEM_DATA/MEM_STRB = 0.
  - EMPTY = 1, FULL = 0, LOOKUP_HIT = 0.
  - Queued and in-flight entries are discarded, including a request awaiting MEM_ACK.
- Storage:
  - Circular FIFO of {addr, data, strb}.
  - Pointers are log2(DEPTH)+1 bits; the extra bit distinguishes full from empty.
  - count ranges 0..DEPTH.
- Enqueue:
  - Happens when WR_VALID && WR_READY at a rising edge.
  - WR_READY = !FULL, combinational; no same-cycle bypass from a pop.
  - WR_VALID with WR_STRB = 0 is still enqueued.
- Drain FSM, states IDLE and REQ:
  - IDLE: if count > 0, latch the head entry into MEM_*, set MEM_REQ = 1, go to REQ.
  - Latency: a write accepted at edge k into an empty buffer gives MEM_REQ high after edge k+1.
  - REQ: MEM_REQ and MEM_* are held stable until MEM_ACK.
  - On MEM_ACK: pop the head.
    - If entries remain beyond the popped one, latch the next head and stay in REQ (back-to-back, no bubble).
    - Otherwise clear MEM_REQ and go to IDLE.
  - MEM_ACK in IDLE is ignored.
- The head entry stays counted and visible to lookup until its MEM_ACK.
- Simultaneous enqueue and MEM_ACK:
  - Both take effect; count is unchanged.
  - The newly enqueued entry is not eligible for the back-to-back latch at that same edge.
- Lookup (combinational):
  - Compare word addresses only (ignore the low log2(DATA_WIDTH/8) bits) against all valid entries.
  - If several entries match, the youngest wins.
  - On a miss, LOOKUP_DATA and LOOKUP_STRB = 0.
  - Merging bytes across entries is the caller's job, not this block's.
- Flags are combinational from the pointers:
  - EMPTY = (count == 0).
  - FULL = (count == DEPTH).

Optional Feature:
- Macro: DCACHE_WB_COALESCE_EN.
- Defined:
  - A write whose word address equals the youngest entry's merges into that entry instead of allocating, provided count ≥ 2 (the youngest is not the head/in-flight entry).
  - Merge rule: bytes with WR_STRB set overwrite the stored bytes; the stored strobe becomes the OR of old and new.
  - Coalescing writes are accepted even when FULL (WR_READY = !FULL || coalesce_hit) and leave count unchanged.
- Undefined: every write allocates a new entry.

Test Plan:
- Reset, then a write of addr 0x100, data 0xDEADBEEF, strb 0xF → MEM_REQ high one cycle later with the same values; hold MEM_ACK low for 3 cycles → outputs stable; ACK → MEM_REQ 0 next cycle, EMPTY = 1.
- Four writes to 0x0/0x4/0x8/0xC with MEM_ACK held low → FULL = 1 and WR_READY = 0 after the 4th; a 5th write stalls; ACK every cycle → four back-to-back requests with no bubble, in order.
- Writes 0x20 = 0x11111111 then 0x20 = 0x22222222; LOOKUP_ADDR 0x22 → LOOKUP_HIT = 1, LOOKUP_DATA = 0x22222222; LOOKUP_ADDR 0x24 → LOOKUP_HIT = 0, LOOKUP_DATA = 0.
- Enqueue and MEM_ACK at the same edge with count = 2 → count stays 2, the next head is issued, FIFO order is preserved.
- RST_N low for one edge while in REQ with 3 entries → MEM_REQ = 0, EMPTY = 1, and a later MEM_ACK has no effect.
- With DCACHE_WB_COALESCE_EN defined: writes 0x40 (strb 0x1, data 0xAA) then 0x40 (strb 0x4, data 0xBB0000) while another entry is in flight → a single entry with strb 0x5 and bytes 0/2 = AA/BB; without the macro → two entries.

Source files
------------

// File: rtl/dcache_write_buffer.sv
// Write-through store buffer behind the data cache: a FIFO of {addr, data, strb} drained over a req/ack port,
// plus a combinational youngest-match lookup. Optional write coalescing under `DCACHE_WB_COALESCE_EN.
module dcache_write_buffer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
)(
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      WR_VALID,
  output logic                      WR_READY,
  input  logic [ADDRESS_WIDTH-1:0]  WR_ADDR,
  input  logic [DATA_WIDTH-1:0]     WR_DATA,
  input  logic [DATA_WIDTH/8-1:0]   WR_STRB,
  input  logic [ADDRESS_WIDTH-1:0]  LOOKUP_ADDR,
  output logic                      LOOKUP_HIT,
  output logic [DATA_WIDTH-1:0]     LOOKUP_DATA,
  output logic [DATA_WIDTH/8-1:0]   LOOKUP_STRB,
  output logic                      MEM_REQ,
  output logic [ADDRESS_WIDTH-1:0]  MEM_ADDR,
  output logic [DATA_WIDTH-1:0]     MEM_DATA,
  output logic [DATA_WIDTH/8-1:0]   MEM_STRB,
  input  logic                      MEM_ACK,
  output logic                      EMPTY,
  output logic                      FULL
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK = {ADDRESS_WIDTH{1'b1}} << OFF_W;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
    logic [STRB_W-1:0]        strb;
  } entry_t;

  typedef enum logic {IDLE, REQ} state_t;

  entry_t             fifo [DEPTH];
  logic [PTR_W-1:0]   head, tail, count;
  state_t             state, state_nx;
  logic               push, pop, merge, load, clr;
  logic [IDX_W-1:0]   load_idx;

  assign count    = tail - head;
  assign EMPTY    = (count == '0);
  assign FULL     = (count == PTR_W'(DEPTH));
  assign pop      = (state == REQ) && MEM_ACK;

`ifdef DCACHE_WB_COALESCE_EN
  logic [IDX_W-1:0] yi;
  logic             co_hit;
  assign yi = tail[IDX_W-1:0] - IDX_W'(1);
  // The youngest must not be in flight now, nor become in flight via a back-to-back latch at this edge.
  assign co_hit = (count > PTR_W'(2) || (count == PTR_W'(2) && !pop)) &&
                  (((fifo[yi].addr ^ WR_ADDR) & WORD_MASK) == '0);
  assign WR_READY = !FULL || co_hit;
  assign merge    = WR_VALID && co_hit;
`else
  assign WR_READY = !FULL;
  assign merge    = 1'b0;
`endif

  assign push = WR_VALID && WR_READY && !merge;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      head  <= '0;
      tail  <= '0;
      state <= IDLE;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      state <= state_nx;
    end
  end

  // Payload storage carries no reset; validity comes from the pointers alone.
  always_ff @(posedge CLK) begin
    if (push) fifo[tail[IDX_W-1:0]] <= '{addr: WR_ADDR, data: WR_DATA, strb: WR_STRB};
`ifdef DCACHE_WB_COALESCE_EN
    if (merge) begin
      for (int b = 0; b < STRB_W; b++)
        if (WR_STRB[b]) fifo[yi].data[8*b +: 8] <= WR_DATA[8*b +: 8];
      fifo[yi].strb <= fifo[yi].strb | WR_STRB;
    end
`endif
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    clr      = 1'b0;
    load_idx = head[IDX_W-1:0];
    case (state)
      IDLE: if (count != '0) begin
        load     = 1'b1;
        state_nx = REQ;
      end
      REQ: if (MEM_ACK) begin
        // count is pre-edge, so a same-edge enqueue never feeds the back-to-back latch.
        if (count > PTR_W'(1)) begin
          load     = 1'b1;
          load_idx = head[IDX_W-1:0] + IDX_W'(1);
        end else begin
          clr      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      MEM_REQ  <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DATA <= '0;
      MEM_STRB <= '0;
    end else if (load) begin
      MEM_REQ  <= 1'b1;
      MEM_ADDR <= fifo[load_idx].addr;
      MEM_DATA <= fifo[load_idx].data;
      MEM_STRB <= fifo[load_idx].strb;
    end else if (clr) begin
      MEM_REQ  <= 1'b0;
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    LOOKUP_HIT  = 1'b0;
    LOOKUP_DATA = '0;
    LOOKUP_STRB = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (PTR_W'(k) < count &&
          ((fifo[IDX_W'(head + PTR_W'(k))].addr ^ LOOKUP_ADDR) & WORD_MASK) == '0) begin
        LOOKUP_HIT  = 1'b1;
        LOOKUP_DATA = fifo[IDX_W'(head + PTR_W'(k))].data;
        LOOKUP_STRB = fifo[IDX_W'(head + PTR_W'(k))].strb;
      end
    end
  end
endmodule

// File: tb/tb_dcache_write_buffer.sv
// Scoreboard bench for dcache_write_buffer: directed writes push expected memory requests,
// a monitor pops and compares on every accepted MEM_REQ/MEM_ACK handshake.
module tb_dcache_write_buffer;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        WR_VALID, WR_READY;
  logic [31:0] WR_ADDR, WR_DATA, LOOKUP_ADDR, LOOKUP_DATA, MEM_ADDR, MEM_DATA;
  logic [3:0]  WR_STRB, LOOKUP_STRB, MEM_STRB;
  logic        LOOKUP_HIT, MEM_REQ, MEM_ACK, EMPTY, FULL;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  dcache_write_buffer #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_STRB(WR_STRB),
    .LOOKUP_ADDR(LOOKUP_ADDR), .LOOKUP_HIT(LOOKUP_HIT), .LOOKUP_DATA(LOOKUP_DATA), .LOOKUP_STRB(LOOKUP_STRB),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_STRB(MEM_STRB), .MEM_ACK(MEM_ACK),
    .EMPTY(EMPTY), .FULL(FULL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_q.push_back({a, d, s});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    WR_VALID = 1'b1; WR_ADDR = a; WR_DATA = d; WR_STRB = s;
    while (!WR_READY && n < 20) begin tick(); n++; end
    if (!WR_READY) chk("wr_ready_timeout", 64'(WR_READY), 64'd1);
    tick();
    WR_VALID = 1'b0;
  endtask

  task automatic look(input string nm, input logic [31:0] a, input logic hit,
                      input logic [31:0] d, input logic [3:0] s);
    LOOKUP_ADDR = a;
    #1;
    chk({nm, "_hit"},  64'(LOOKUP_HIT),  64'(hit));
    chk({nm, "_data"}, 64'(LOOKUP_DATA), 64'(d));
    chk({nm, "_strb"}, 64'(LOOKUP_STRB), 64'(s));
  endtask

  // Monitor: a request completes at the edge following a negedge where REQ and ACK are both high.
  always @(negedge CLK) begin
    if (RST_N && MEM_REQ && MEM_ACK) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_mem_req", 64'(MEM_ADDR), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mem_addr", 64'(MEM_ADDR), 64'(e.addr));
        chk("mem_data", 64'(MEM_DATA), 64'(e.data));
        chk("mem_strb", 64'(MEM_STRB), 64'(e.strb));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST_N = 1'b0; WR_VALID = 1'b0; WR_ADDR = '0; WR_DATA = '0; WR_STRB = '0;
    LOOKUP_ADDR = '0; MEM_ACK = 1'b0;
    repeat (2) tick();
    RST_N = 1'b1;

    // Reset state
    chk("rst_empty", 64'(EMPTY), 64'd1);
    chk("rst_full", 64'(FULL), 64'd0);
    chk("rst_mem_req", 64'(MEM_REQ), 64'd0);
    chk("rst_mem_addr", 64'(MEM_ADDR), 64'd0);
    chk("rst_mem_data", 64'(MEM_DATA), 64'd0);
    chk("rst_mem_strb", 64'(MEM_STRB), 64'd0);
    chk("rst_lookup_hit", 64'(LOOKUP_HIT), 64'd0);
    chk("rst_wr_ready", 64'(WR_READY), 64'd1);

    // Single write, one-cycle issue latency, stable hold, ack
    expect_req(32'h100, 32'hDEAD_BEEF, 4'hF);
    wr(32'h100, 32'hDEAD_BEEF, 4'hF);
    chk("lat_req_low_k", 64'(MEM_REQ), 64'd0);
    chk("lat_not_empty", 64'(EMPTY), 64'd0);
    tick();
    chk("lat_req_high_k1", 64'(MEM_REQ), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req", 64'(MEM_REQ), 64'd1);
      chk("hold_addr", 64'(MEM_ADDR), 64'h100);
      chk("hold_data", 64'(MEM_DATA), 64'hDEAD_BEEF);
      chk("hold_strb", 64'(MEM_STRB), 64'hF);
    end
    MEM_ACK = 1'b1; tick(); MEM_ACK = 1'b0;
    chk("ack_req_low", 64'(MEM_REQ), 64'd0);
    chk("ack_empty", 64'(EMPTY), 64'd1);

    // Fill to FULL, stall a fifth write, then back-to-back drain
    for (int i = 0; i < 4; i++) begin
      expect_req(32'(4 * i), 32'hA0 + 32'(i), 4'hF);
      wr(32'(4 * i), 32'hA0 + 32'(i), 4'hF);
    end
    chk("fill_full", 64'(FULL), 64'd1);
    chk("fill_wr_ready", 64'(WR_READY), 64'd0);
    WR_VALID = 1'b1; WR_ADDR = 32'h10; WR_DATA = 32'hA4; WR_STRB = 4'hF;
    repeat (2) begin
      tick();
      chk("stall_full", 64'(FULL), 64'd1);
      chk("stall_wr_ready", 64'(WR_READY), 64'd0);
    end
    expect_req(32'h10, 32'hA4, 4'hF);
    MEM_ACK = 1'b1;
    tick();
    chk("b2b_req_1", 64'(MEM_REQ), 64'd1);
    chk("b2b_ready_after_pop", 64'(WR_READY), 64'd1);
    tick();
    WR_VALID = 1'b0;
    chk("b2b_req_2", 64'(MEM_REQ), 64'd1);
    tick(); chk("b2b_req_3", 64'(MEM_REQ), 64'd1);
    tick(); chk("b2b_req_4", 64'(MEM_REQ), 64'd1);
    tick(); MEM_ACK = 1'b0;
    chk("b2b_done_req", 64'(MEM_REQ), 64'd0);
    chk("b2b_done_empty", 64'(EMPTY), 64'd1);

    // Lookup: youngest match wins, word-granular compare, miss returns zero
    expect_req(32'h20, 32'h1111_1111, 4'hF);
    wr(32'h20, 32'h1111_1111, 4'hF);
    expect_req(32'h20, 32'h2222_2222, 4'h3);
    wr(32'h20, 32'h2222_2222, 4'h3);
    look("lk_22", 32'h22, 1'b1, 32'h2222_2222, 4'h3);
    look("lk_24", 32'h24, 1'b0, 32'h0, 4'h0);
    look("lk_100", 32'h100, 1'b0, 32'h0, 4'h0);
    MEM_ACK = 1'b1; repeat (2) tick(); MEM_ACK = 1'b0;
    chk("lk_drain_empty", 64'(EMPTY), 64'd1);

    // Enqueue and ack at the same edge with two entries
    expect_req(32'h30, 32'hD0, 4'hF); wr(32'h30, 32'hD0, 4'hF);
    expect_req(32'h34, 32'hD1, 4'hF); wr(32'h34, 32'hD1, 4'hF);
    expect_req(32'h38, 32'hD2, 4'hF);
    MEM_ACK = 1'b1; wr(32'h38, 32'hD2, 4'hF); MEM_ACK = 1'b0;
    chk("sim_req", 64'(MEM_REQ), 64'd1);
    chk("sim_next_head", 64'(MEM_ADDR), 64'h34);
    look("sim_lk_30", 32'h30, 1'b0, 32'h0, 4'h0);
    look("sim_lk_34", 32'h34, 1'b1, 32'hD1, 4'hF);
    look("sim_lk_38", 32'h38, 1'b1, 32'hD2, 4'hF);
    MEM_ACK = 1'b1;
    tick();
    chk("sim_third_addr", 64'(MEM_ADDR), 64'h38);
    chk("sim_third_req", 64'(MEM_REQ), 64'd1);
    tick(); MEM_ACK = 1'b0;
    chk("sim_done_req", 64'(MEM_REQ), 64'd0);
    chk("sim_done_empty", 64'(EMPTY), 64'd1);

    // Reset while a request is outstanding
    wr(32'h50, 32'hE0, 4'hF); wr(32'h54, 32'hE1, 4'hF); wr(32'h58, 32'hE2, 4'hF);
    chk("mr_pre_req", 64'(MEM_REQ), 64'd1);
    RST_N = 1'b0; tick(); RST_N = 1'b1;
    exp_q.delete();
    chk("mr_req", 64'(MEM_REQ), 64'd0);
    chk("mr_addr", 64'(MEM_ADDR), 64'd0);
    chk("mr_empty", 64'(EMPTY), 64'd1);
    look("mr_lk_54", 32'h54, 1'b0, 32'h0, 4'h0);
    MEM_ACK = 1'b1; tick(); MEM_ACK = 1'b0;
    chk("mr_ack_req", 64'(MEM_REQ), 64'd0);
    chk("mr_ack_empty", 64'(EMPTY), 64'd1);
    chk("mr_ack_full", 64'(FULL), 64'd0);
    tick();
    chk("mr_idle_req", 64'(MEM_REQ), 64'd0);

    // Same-word writes behind an in-flight entry
    expect_req(32'h60, 32'h1, 4'hF);
    wr(32'h60, 32'h1, 4'hF);
    wr(32'h40, 32'h0000_00AA, 4'h1);
    wr(32'h40, 32'h00BB_0000, 4'h4);
`ifdef DCACHE_WB_COALESCE_EN
    expect_req(32'h40, 32'h00BB_00AA, 4'h5);
    look("co_lk_40", 32'h40, 1'b1, 32'h00BB_00AA, 4'h5);
`else
    expect_req(32'h40, 32'h0000_00AA, 4'h1);
    expect_req(32'h40, 32'h00BB_0000, 4'h4);
    look("co_lk_40", 32'h40, 1'b1, 32'h00BB_0000, 4'h4);
`endif
    MEM_ACK = 1'b1;
    n = 0;
    while (!EMPTY && n < 10) begin tick(); n++; end
    MEM_ACK = 1'b0;
    chk("co_drain_empty", 64'(EMPTY), 64'd1);
    tick();
    chk("final_exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
